// File: rtl/ro_gate_ctrl.sv
// Gated ring-oscillator measurement controller: clears the external counter, opens the
// enable window for a fixed number of clk cycles, lets the count settle, then samples it.
module ro_gate_ctrl #(
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 1000,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CONTINUOUS    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             cnt_reset,
    output logic             cnt_enable,
    input  logic [CNT_W-1:0] cnt_value,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam int MAX_WC  = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC = (MAX_WC > SETTLE_CYCLES) ? MAX_WC : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] CLEAR_LD  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

    // state    | meaning
    // S_IDLE   | counter held in reset, waiting for start
    // S_CLEAR  | counter reset pulse before the window
    // S_GATE   | enable window open
    // S_SETTLE | gate closed, async count settling
    // S_SAMPLE | capture the frozen count
    // S_HOLD   | result presented, counter frozen until handshake
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               cnt_reset_q, cnt_reset_d;
    logic               cnt_enable_q, cnt_enable_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            cnt_reset_q  <= 1'b1;
            cnt_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            cnt_reset_q  <= cnt_reset_d;
            cnt_enable_q <= cnt_enable_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
        result_d = result_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    timer_d = CLEAR_LD;
                end
            end
            S_CLEAR: begin
                if (timer_q == '0) begin
                    state_d = S_GATE;
                    timer_d = WINDOW_LD;
                end
            end
            S_GATE: begin
                if (timer_q == '0) begin
                    state_d = S_SETTLE;
                    timer_d = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                state_d  = S_HOLD;
                result_d = cnt_value;
                valid_d  = 1'b1;
            end
            S_HOLD: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    timer_d = CLEAR_LD;
                    state_d = (CONTINUOUS != 0) ? S_CLEAR : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they switch on the same edge as the state.
        cnt_reset_d  = (state_d == S_IDLE) || (state_d == S_CLEAR);
        cnt_enable_d = (state_d == S_GATE);
        busy_d       = (state_d == S_CLEAR) || (state_d == S_GATE) ||
                       (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    end

    assign cnt_reset    = cnt_reset_q;
    assign cnt_enable   = cnt_enable_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ro_gate_ctrl.sv
// Bench for ro_gate_ctrl: behavioural ring-oscillator counters drive one single-shot and
// one continuous instance; results are checked against the nominal count W*Tclk/Tro.
`timescale 1ns/1ps
module tb_ro_gate_ctrl;

    localparam int W   = 100;
    localparam int C   = 2;
    localparam int S   = 4;
    localparam int LAT = C + W + S + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, ready_a, cnt_reset_a, cnt_enable_a, valid_a, busy_a;
    logic [15:0] result_a;
    logic [15:0] cnt_a = '0;
    logic        start_b, ready_b, cnt_reset_b, cnt_enable_b, valid_b, busy_b;
    logic [15:0] result_b;
    logic [15:0] cnt_b = '0;

    logic ro_in = 1'b0;
    real  ro_half = 2.0;
    always #(ro_half) ro_in = ~ro_in;

    always @(posedge ro_in or posedge cnt_reset_a)
        if (cnt_reset_a) cnt_a <= '0;
        else if (cnt_enable_a) cnt_a <= cnt_a + 16'd1;

    always @(posedge ro_in or posedge cnt_reset_b)
        if (cnt_reset_b) cnt_b <= '0;
        else if (cnt_enable_b) cnt_b <= cnt_b + 16'd1;

    ro_gate_ctrl #(.CNT_W(16), .WINDOW_CYCLES(W), .CLEAR_CYCLES(C), .SETTLE_CYCLES(S),
                   .CONTINUOUS(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cnt_reset(cnt_reset_a),
        .cnt_enable(cnt_enable_a), .cnt_value(cnt_a), .result(result_a),
        .result_valid(valid_a), .result_ready(ready_a), .busy(busy_a));

    ro_gate_ctrl #(.CNT_W(16), .WINDOW_CYCLES(W), .CLEAR_CYCLES(C), .SETTLE_CYCLES(S),
                   .CONTINUOUS(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cnt_reset(cnt_reset_b),
        .cnt_enable(cnt_enable_b), .cnt_value(cnt_b), .result(result_b),
        .result_valid(valid_b), .result_ready(ready_b), .busy(busy_b));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Nominal count is W clock periods of 10 ns divided by the oscillator period, mod 2^16.
    task automatic check_res(input string tag, input logic [15:0] r, input real period);
        int          nominal;
        logic [15:0] d;
        nominal = $rtoi(W * 10.0 / period + 0.5);
        d = r - 16'(nominal);
        total++;
        assert ((d == 16'd0 || d == 16'd1 || d == 16'hFFFF) === 1'b1) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d+-1", tag, r, nominal % 65536);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_a(input real period, input int ready_delay, input bit poke_start);
        logic [15:0] r0;
        int n;
        int en;
        ready_a = (ready_delay == 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("busy_after_start", busy_a, 1);
        n  = 0;
        en = 0;
        while (!valid_a && n < LAT + 20) begin
            if (cnt_enable_a) en++;
            tick();
            n++;
        end
        check("valid_latency", n, LAT);
        check("enable_cycles", en, W);
        check("busy_at_valid", busy_a, 0);
        check_res("result", result_a, period);
        r0 = result_a;
        if (ready_delay == 0) begin
            tick();
            check("valid_pulse", valid_a, 0);
        end else begin
            for (int i = 0; i < ready_delay; i++) begin
                start_a = poke_start && (i == ready_delay / 2);
                tick();
                check("hold_valid", valid_a, 1);
                check("hold_result", result_a, r0);
                check("hold_not_busy", busy_a, 0);
            end
            start_a = 1'b0;
            ready_a = 1'b1;
            tick();
            check("valid_drop", valid_a, 0);
            check("idle_cnt_reset", cnt_reset_a, 1);
            tick();
            check("no_restart", busy_a, 0);
        end
        check("result_retained", result_a, r0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc;
        real p;

        reset   = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;
        #1;
        check("rst_cnt_reset", cnt_reset_a, 1);
        check("rst_cnt_enable", cnt_enable_a, 0);
        check("rst_result", result_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_cnt_reset", cnt_reset_b, 1);
        check("rst_b_valid", valid_b, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_no_start", busy_a, 0);

        // single measurement, 4 ns oscillator
        ro_half = 2.0;
        measure_a(4.0, 0, 1'b0);

        // backpressure with a start poke during HOLD
        measure_a(4.0, 20, 1'b1);

        // wrap-around: 100000 counts
        ro_half = 0.005;
        measure_a(0.01, 3, 1'b0);
        ro_half = 2.0;

        // continuous instance: 4 ns then 5 ns
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!valid_b && n < LAT + 20) begin tick(); n++; end
        check("cont_latency1", n, LAT);
        check_res("cont_result1", result_b, 4.0);
        ro_half = 2.5;
        tick();
        check("cont_valid_drop", valid_b, 0);
        check("cont_rearm_reset", cnt_reset_b, 1);
        check("cont_rearm_busy", busy_b, 1);
        n  = 0;
        rc = 0;
        while (!valid_b && n < LAT + 20) begin
            if (cnt_reset_b) rc++;
            tick();
            n++;
        end
        check("cont_latency2", n, LAT);
        check("cont_reset_cycles", rc, C);
        check_res("cont_result2", result_b, 5.0);
        ready_b = 1'b0;
        ro_half = 2.0;
        tick();

        // reset in the middle of the gate window
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (C + 50) tick();
        check("midgate_enable_on", cnt_enable_a, 1);
        #3 reset = 1'b1;
        #1;
        check("midgate_enable", cnt_enable_a, 0);
        check("midgate_cnt_reset", cnt_reset_a, 1);
        check("midgate_valid", valid_a, 0);
        check("midgate_busy", busy_a, 0);
        check("midgate_result", result_a, 0);
        tick();
        reset = 1'b0;
        tick();
        measure_a(4.0, 0, 1'b0);

        // start held high in single-shot mode: back-to-back measurements
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        n = 0;
        while (!valid_a && n < LAT + 20) begin tick(); n++; end
        check("b2b_latency1", n, LAT);
        check_res("b2b_result1", result_a, 4.0);
        tick();
        check("b2b_idle", busy_a, 0);
        tick();
        check("b2b_restart", busy_a, 1);
        n = 0;
        while (!valid_a && n < LAT + 20) begin tick(); n++; end
        check("b2b_latency2", n, LAT);
        start_a = 1'b0;
        tick();
        tick();

        // randomized oscillator periods and backpressure
        for (int k = 0; k < 6; k++) begin
            p = real'($urandom_range(2, 9)) + 0.02 * real'($urandom_range(0, 49));
            ro_half = p / 2.0;
            measure_a(p, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
